// File: rtl/fft_r2_butterfly_if.sv
// Operand/result handshake bundle for the radix-2 butterfly.
// slave is the butterfly's view, master is the upstream/downstream driver's view.
interface fft_r2_butterfly_if #(
  parameter int DW = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] a_re, a_im;
  logic signed [DW-1:0] b_re, b_im;
  logic signed [DW-1:0] w_re, w_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] x_re, x_im;
  logic signed [DW-1:0] y_re, y_im;
  logic                 ovf;
  logic                 ovf_clr;

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, w_re, w_im, out_ready, ovf_clr,
    output in_ready, out_valid, x_re, x_im, y_re, y_im, ovf
  );

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, w_re, w_im, out_ready, ovf_clr,
    input  in_ready, out_valid, x_re, x_im, y_re, y_im, ovf
  );
endinterface

// File: rtl/fft_r2_butterfly.sv
// Radix-2 DIT butterfly X = A + W*B, Y = A - W*B on signed fixed-point; 3 enabled cycles latency.
// Backpressure: in_ready = !out_valid | out_ready, and all three stages stall together.
module fft_r2_butterfly #(
  parameter int DW    = 32,
  parameter int FRAC  = 16,
  parameter int SCALE = 0
) (
  input logic               clk,
  input logic               rst,
  fft_r2_butterfly_if.slave io
);
  localparam int PW = 2 * DW;
  localparam int WW = 2 * DW + 2;
  localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [WW-1:0] RND  = WW'(1) <<< (FRAC - 1);

  function automatic logic oor(input logic signed [WW-1:0] v);
    return (v > WW'(DMAX)) || (v < WW'(DMIN));
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [WW-1:0] v);
    if (v > WW'(DMAX)) return DMAX;
    if (v < WW'(DMIN)) return DMIN;
    return v[DW-1:0];
  endfunction

  // Scaled mode still passes through sat() so a saturated -t corner cannot wrap.
  function automatic logic signed [WW-1:0] scl(input logic signed [WW-1:0] v);
    if (SCALE != 0) return (v + WW'(1)) >>> 1;
    return v;
  endfunction

  logic                 en;
  logic                 v1, v2, v3;
  logic signed [DW-1:0] a1_re, a1_im, a2_re, a2_im;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [DW-1:0] t2_re, t2_im;
  logic signed [DW:0]   nt2_re, nt2_im;
  logic signed [DW-1:0] x_re_q, x_im_q, y_re_q, y_im_q;
  logic                 ovf_q;

  logic signed [WW-1:0] t_re_w, t_im_w;
  logic signed [DW-1:0] t_re_s, t_im_s;
  logic signed [WW-1:0] sx_re_w, sx_im_w, sy_re_w, sy_im_w;
  logic                 sat2, sat3;

  assign en          = !v3 || io.out_ready;
  assign io.in_ready = en;

  assign t_re_w = (WW'(p_rr) - WW'(p_ii) + RND) >>> FRAC;
  assign t_im_w = (WW'(p_ri) + WW'(p_ir) + RND) >>> FRAC;
  assign t_re_s = sat(t_re_w);
  assign t_im_s = sat(t_im_w);
  assign sat2   = oor(t_re_w) || oor(t_im_w);

  assign sx_re_w = scl(WW'(a2_re) + WW'(t2_re));
  assign sx_im_w = scl(WW'(a2_im) + WW'(t2_im));
  assign sy_re_w = scl(WW'(a2_re) + WW'(nt2_re));
  assign sy_im_w = scl(WW'(a2_im) + WW'(nt2_im));
  assign sat3    = oor(sx_re_w) || oor(sx_im_w) || oor(sy_re_w) || oor(sy_im_w);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      a1_re  <= '0;
      a1_im  <= '0;
      a2_re  <= '0;
      a2_im  <= '0;
      p_rr   <= '0;
      p_ii   <= '0;
      p_ri   <= '0;
      p_ir   <= '0;
      t2_re  <= '0;
      t2_im  <= '0;
      nt2_re <= '0;
      nt2_im <= '0;
      x_re_q <= '0;
      x_im_q <= '0;
      y_re_q <= '0;
      y_im_q <= '0;
    end else if (en) begin
      v1     <= io.in_valid;
      a1_re  <= io.a_re;
      a1_im  <= io.a_im;
      p_rr   <= PW'(io.b_re) * PW'(io.w_re);
      p_ii   <= PW'(io.b_im) * PW'(io.w_im);
      p_ri   <= PW'(io.b_re) * PW'(io.w_im);
      p_ir   <= PW'(io.b_im) * PW'(io.w_re);
      v2     <= v1;
      a2_re  <= a1_re;
      a2_im  <= a1_im;
      t2_re  <= t_re_s;
      t2_im  <= t_im_s;
      // One extra bit keeps -(-2^(DW-1)) exact.
      nt2_re <= -((DW+1)'(t_re_s));
      nt2_im <= -((DW+1)'(t_im_s));
      v3     <= v2;
      x_re_q <= sat(sx_re_w);
      x_im_q <= sat(sx_im_w);
      y_re_q <= sat(sy_re_w);
      y_im_q <= sat(sy_im_w);
    end
  end

  // Set wins over clear; bubbles never flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (en && ((v1 && sat2) || (v2 && sat3))) begin
      ovf_q <= 1'b1;
    end else if (io.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign io.out_valid = v3;
  assign io.x_re      = x_re_q;
  assign io.x_im      = x_im_q;
  assign io.y_re      = y_re_q;
  assign io.y_im      = y_im_q;
  assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_fft_r2_butterfly.sv
// Bench for fft_r2_butterfly: directed scenarios plus randomized streams scored
// against a wide-integer reference model of the butterfly arithmetic.
module tb_fft_r2_butterfly;
  localparam int DW = 32;
  localparam logic signed [31:0] ONE = 32'sh0001_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_r2_butterfly_if #(.DW(DW)) b0 ();
  fft_r2_butterfly_if #(.DW(DW)) b1 ();

  fft_r2_butterfly #(.DW(DW), .FRAC(16), .SCALE(0)) u0 (.clk(clk), .rst(rst), .io(b0));
  fft_r2_butterfly #(.DW(DW), .FRAC(16), .SCALE(1)) u1 (.clk(clk), .rst(rst), .io(b1));

  typedef struct {
    logic signed [31:0] a_re, a_im, b_re, b_im, w_re, w_im;
  } beat_t;

  typedef struct {
    logic signed [31:0] x_re, x_im, y_re, y_im;
    bit                 sat;
  } res_t;

  int    errors = 0;
  int    checks = 0;
  beat_t stim_q[$];
  res_t  exp_q[$];
  bit    run_sat;
  int    n_out;
  logic signed [31:0] last_x_re, last_x_im, last_y_re, last_y_im;

  function automatic bit oor(input logic signed [127:0] v);
    return (v > 128'sd2147483647) || (v < -128'sd2147483648);
  endfunction

  function automatic logic signed [31:0] clamp(input logic signed [127:0] v);
    if (v > 128'sd2147483647) return 32'sh7FFFFFFF;
    if (v < -128'sd2147483648) return 32'sh80000000;
    return v[31:0];
  endfunction

  // Plain integer butterfly: round-half-up product, clamp, add/sub, optional halving.
  function automatic res_t model(input beat_t s, input bit scale);
    logic signed [127:0] ar, ai, br, bi, wr, wi, tr, ti, xr, xi, yr, yi;
    res_t r;
    ar = s.a_re; ai = s.a_im; br = s.b_re; bi = s.b_im; wr = s.w_re; wi = s.w_im;
    tr = (br * wr - bi * wi + 128'sd32768) >>> 16;
    ti = (br * wi + bi * wr + 128'sd32768) >>> 16;
    r.sat = oor(tr) | oor(ti);
    tr = clamp(tr);
    ti = clamp(ti);
    xr = ar + tr; xi = ai + ti; yr = ar - tr; yi = ai - ti;
    if (scale) begin
      xr = (xr + 1) >>> 1; xi = (xi + 1) >>> 1;
      yr = (yr + 1) >>> 1; yi = (yi + 1) >>> 1;
    end
    r.sat = r.sat | oor(xr) | oor(xi) | oor(yr) | oor(yi);
    r.x_re = clamp(xr); r.x_im = clamp(xi); r.y_re = clamp(yr); r.y_im = clamp(yi);
    return r;
  endfunction

  function automatic logic signed [31:0] rv();
    logic signed [31:0] v;
    v = $urandom;
    return v >>> $urandom_range(0, 14);
  endfunction

  function automatic beat_t rand_beat();
    beat_t s;
    s.a_re = rv(); s.a_im = rv(); s.b_re = rv(); s.b_im = rv(); s.w_re = rv(); s.w_im = rv();
    return s;
  endfunction

  function automatic beat_t zero_beat();
    beat_t s;
    s.a_re = 0; s.a_im = 0; s.b_re = 0; s.b_im = 0; s.w_re = 0; s.w_im = 0;
    return s;
  endfunction

  task automatic drive0(input beat_t s);
    b0.a_re = s.a_re; b0.a_im = s.a_im; b0.b_re = s.b_re;
    b0.b_im = s.b_im; b0.w_re = s.w_re; b0.w_im = s.w_im;
  endtask

  // rmode: 0 always ready, 1 random ready, 2 stalled for cycles 2..8. vmode: 0 dense, 1 random bubbles.
  task automatic run(input int rmode, input int vmode);
    int   cyc;
    bit   vld;
    res_t e, r;
    cyc   = 0;
    n_out = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < 4000) begin
      cyc++;
      vld = (stim_q.size() > 0) && (vmode == 0 || $urandom_range(0, 2) != 0);
      b0.in_valid = vld;
      if (vld) drive0(stim_q[0]);
      else drive0(rand_beat());
      if (rmode == 0) b0.out_ready = 1'b1;
      else if (rmode == 1) b0.out_ready = 1'($urandom_range(0, 1));
      else b0.out_ready = !(cyc >= 2 && cyc <= 8);
      #1;
      if (rmode == 2 && cyc == 8) begin
        checks++;
        if (b0.in_ready !== 1'b0 || exp_q.size() != 3) begin
          errors++;
          $display("FAIL stall_hold: in_ready=%b held=%0d, required in_ready=0 held=3", b0.in_ready, exp_q.size());
        end
      end
      if (b0.out_valid && b0.out_ready) begin
        checks++;
        n_out++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: unexpected beat x_re=%h", b0.x_re);
        end else begin
          e = exp_q.pop_front();
          if (b0.x_re !== e.x_re || b0.x_im !== e.x_im || b0.y_re !== e.y_re || b0.y_im !== e.y_im) begin
            errors++;
            $display("FAIL stream_beat %0d: got X=(%h,%h) Y=(%h,%h) required X=(%h,%h) Y=(%h,%h)",
                     n_out, b0.x_re, b0.x_im, b0.y_re, b0.y_im, e.x_re, e.x_im, e.y_re, e.y_im);
          end
        end
        last_x_re = b0.x_re; last_x_im = b0.x_im; last_y_re = b0.y_re; last_y_im = b0.y_im;
      end
      if (vld && b0.in_ready) begin
        r = model(stim_q.pop_front(), 1'b0);
        run_sat = run_sat | r.sat;
        exp_q.push_back(r);
      end
      @(posedge clk); #1;
    end
    b0.in_valid  = 1'b0;
    b0.out_ready = 1'b1;
    checks++;
    if (stim_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_timeout: pending in=%0d out=%0d, required 0/0", stim_q.size(), exp_q.size());
      stim_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic lat_beat(input beat_t s, output int lat);
    drive0(s);
    b0.in_valid  = 1'b1;
    b0.out_ready = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) b0.in_valid = 1'b0;
      if (b0.out_valid) begin
        lat = k;
        break;
      end
    end
    last_x_re = b0.x_re; last_x_im = b0.x_im; last_y_re = b0.y_re; last_y_im = b0.y_im;
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    b0.ovf_clr = 1'b1;
    @(posedge clk); #1;
    b0.ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    b0.in_valid = 1'b0; b0.out_ready = 1'b1; b0.ovf_clr = 1'b0; drive0(zero_beat());
    b1.in_valid = 1'b0; b1.out_ready = 1'b1; b1.ovf_clr = 1'b0;
    b1.a_re = 0; b1.a_im = 0; b1.b_re = 0; b1.b_im = 0; b1.w_re = 0; b1.w_im = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", b0.out_valid); end
    checks++;
    if ({b0.x_re, b0.x_im, b0.y_re, b0.y_im} !== 128'd0) begin
      errors++; $display("FAIL reset_xy: got %h %h %h %h required 0", b0.x_re, b0.x_im, b0.y_re, b0.y_im);
    end
    checks++;
    if (b0.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b required 0", b0.ovf); end
    checks++;
    if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", b0.in_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    beat_t s;
    int    lat;
    s = zero_beat();
    s.a_re = 32'sh0002_0000; s.b_re = ONE; s.w_re = ONE;
    lat_beat(s, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL latency: got %0d cycles required 3", lat); end
    checks++;
    if (last_x_re !== 32'sh0003_0000 || last_x_im !== 0) begin
      errors++; $display("FAIL basic_x: got (%h,%h) required (00030000,0)", last_x_re, last_x_im);
    end
    checks++;
    if (last_y_re !== 32'sh0001_0000 || last_y_im !== 0) begin
      errors++; $display("FAIL basic_y: got (%h,%h) required (00010000,0)", last_y_re, last_y_im);
    end
  endtask

  task automatic test_twiddle_j();
    beat_t s;
    s = zero_beat();
    s.b_re = ONE; s.w_im = 32'shFFFF_0000;
    stim_q.push_back(s);
    run(0, 0);
    checks++;
    if (last_x_re !== 0 || last_x_im !== 32'shFFFF_0000) begin
      errors++; $display("FAIL twiddle_x: got (%h,%h) required (0,ffff0000)", last_x_re, last_x_im);
    end
    checks++;
    if (last_y_re !== 0 || last_y_im !== 32'sh0001_0000) begin
      errors++; $display("FAIL twiddle_y: got (%h,%h) required (0,00010000)", last_y_re, last_y_im);
    end
  endtask

  task automatic test_saturation();
    beat_t s;
    pulse_clr();
    s = zero_beat();
    s.a_re = 32'sh7FFF_0000; s.b_re = 32'sh7FFF_0000; s.w_re = ONE;
    stim_q.push_back(s);
    run(0, 0);
    checks++;
    if (last_x_re !== 32'sh7FFF_FFFF) begin errors++; $display("FAIL sat_x: got %h required 7fffffff", last_x_re); end
    checks++;
    if (last_y_re !== 0) begin errors++; $display("FAIL sat_y: got %h required 0", last_y_re); end
    checks++;
    if (b0.ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_set: got %b required 1", b0.ovf); end
    pulse_clr();
    checks++;
    if (b0.ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_clr: got %b required 0", b0.ovf); end
  endtask

  task automatic test_backpressure();
    beat_t s;
    for (int i = 1; i <= 6; i++) begin
      s = zero_beat();
      s.a_re = i; s.b_re = 100; s.w_re = ONE;
      stim_q.push_back(s);
    end
    run(2, 0);
    checks++;
    if (n_out != 6 || last_x_re !== 32'sd106) begin
      errors++; $display("FAIL bp_count: got %0d beats last x_re=%0d required 6 beats last 106", n_out, last_x_re);
    end
    checks++;
    if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup: out_valid=%b after drain required 0", b0.out_valid); end
  endtask

  task automatic test_reset_flight();
    beat_t s;
    int    lat;
    res_t  e;
    s = zero_beat();
    s.a_re = 32'sh7FFF_0000; s.b_re = 32'sh7FFF_0000; s.w_re = ONE;
    stim_q.push_back(s);
    run(0, 0);
    drive0(rand_beat());
    b0.in_valid  = 1'b1;
    b0.out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_flight_valid: got %b required 0", b0.out_valid); end
    checks++;
    if ({b0.x_re, b0.x_im, b0.y_re, b0.y_im} !== 128'd0) begin
      errors++; $display("FAIL rst_flight_xy: got %h %h %h %h required 0", b0.x_re, b0.x_im, b0.y_re, b0.y_im);
    end
    checks++;
    if (b0.ovf !== 1'b0) begin errors++; $display("FAIL rst_flight_ovf: got %b required 0", b0.ovf); end
    @(posedge clk); #1;
    rst = 1'b1;
    b0.out_ready = 1'b1;
    s = rand_beat();
    e = model(s, 1'b0);
    lat_beat(s, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL rst_flight_latency: got %0d required 3", lat); end
    checks++;
    if (last_x_re !== e.x_re || last_y_im !== e.y_im) begin
      errors++; $display("FAIL rst_flight_data: got x_re=%h y_im=%h required %h %h", last_x_re, last_y_im, e.x_re, e.y_im);
    end
  endtask

  task automatic test_scale();
    int got;
    b1.a_re = 2; b1.b_re = 1; b1.w_re = ONE;
    b1.in_valid  = 1'b1;
    b1.out_ready = 1'b1;
    got = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) b1.in_valid = 1'b0;
      if (b1.out_valid) begin
        got = k;
        break;
      end
    end
    checks++;
    if (got != 3 || b1.x_re !== 32'sd2) begin
      errors++; $display("FAIL scale_x: got x_re=%0d at cycle %0d required 2 at 3", b1.x_re, got);
    end
    checks++;
    if (b1.y_re !== 32'sd1) begin errors++; $display("FAIL scale_y: got %0d required 1", b1.y_re); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) stim_q.push_back(rand_beat());
    run(0, 0);
    checks++;
    if (n_out != 40) begin errors++; $display("FAIL b2b_count: got %0d required 40", n_out); end
  endtask

  task automatic test_random();
    pulse_clr();
    run_sat = 1'b0;
    for (int i = 0; i < 150; i++) stim_q.push_back(rand_beat());
    run(1, 1);
    checks++;
    if (b0.ovf !== run_sat) begin errors++; $display("FAIL rand_ovf: got %b required %b", b0.ovf, run_sat); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_twiddle_j();
    test_saturation();
    test_backpressure();
    test_reset_flight();
    test_scale();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
